// File: rtl/wb_write_queue.sv
// In-order writeback queue feeding the regfile write port, with youngest-match forwarding for decode.
// Enqueue-to-RegWrite latency is one cycle; in_ready drops once fewer than two free slots remain.
module wb_write_queue #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 5,
  parameter int DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_valid,
  input  logic [ADDRESS_WIDTH-1:0] mem_wa,
  input  logic [DATA_WIDTH-1:0]    mem_wd,
  input  logic                     alu_valid,
  input  logic [ADDRESS_WIDTH-1:0] alu_wa,
  input  logic [DATA_WIDTH-1:0]    alu_wd,
  output logic                     in_ready,
  output logic                     overflow,
  input  logic [ADDRESS_WIDTH-1:0] ra1,
  input  logic [ADDRESS_WIDTH-1:0] ra2,
  output logic                     fwd1_hit,
  output logic [DATA_WIDTH-1:0]    fwd1_data,
  output logic                     fwd2_hit,
  output logic [DATA_WIDTH-1:0]    fwd2_data,
  output logic                     RegWrite,
  output logic [ADDRESS_WIDTH-1:0] wa,
  output logic [DATA_WIDTH-1:0]    wd
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [ADDRESS_WIDTH-1:0] q_wa [DEPTH];
  logic [DATA_WIDTH-1:0]    q_wd [DEPTH];

  ptr_t head;
  ptr_t tail;
  cnt_t count;

  logic mem_req;
  logic alu_req;
  logic mem_take;
  logic alu_take;
  logic deq;
  cnt_t enq_cnt;
  ptr_t alu_slot;

  // Credit comes from the registered count only, so a pop this cycle never frees a slot early.
  assign in_ready = !reset && (count <= cnt_t'(DEPTH - 2));

  assign mem_req  = mem_valid && (mem_wa != '0);
  assign alu_req  = alu_valid && (alu_wa != '0);
  assign mem_take = in_ready && mem_req;
  assign alu_take = in_ready && alu_req;
  assign deq      = (count != '0);
  assign enq_cnt  = cnt_t'(mem_take) + cnt_t'(alu_take);
  assign alu_slot = mem_take ? tail + ptr_t'(1) : tail;

  always_ff @(posedge clk) begin
    if (mem_take) begin
      q_wa[tail] <= mem_wa;
      q_wd[tail] <= mem_wd;
    end
    if (alu_take) begin
      q_wa[alu_slot] <= alu_wa;
      q_wd[alu_slot] <= alu_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      RegWrite <= 1'b0;
      wa       <= '0;
      wd       <= '0;
    end else begin
      if (!in_ready && (mem_req || alu_req)) begin
        overflow <= 1'b1;
      end
      tail  <= tail + ptr_t'(enq_cnt);
      count <= count + enq_cnt - cnt_t'(deq);
      if (deq) begin
        RegWrite <= 1'b1;
        wa       <= q_wa[head];
        wd       <= q_wd[head];
        head     <= head + ptr_t'(1);
      end else begin
        RegWrite <= 1'b0;
      end
    end
  end

  // Scan oldest to youngest so the last match (youngest) overrides; write-port register is lowest priority.
  function automatic logic [DATA_WIDTH:0] lookup(input logic [ADDRESS_WIDTH-1:0] ra);
    logic                  hit;
    logic [DATA_WIDTH-1:0] data;
    ptr_t                  idx;
    hit  = RegWrite && (wa == ra);
    data = wd;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + ptr_t'(k);
      if ((cnt_t'(k) < count) && (q_wa[idx] == ra)) begin
        hit  = 1'b1;
        data = q_wd[idx];
      end
    end
    if (ra == '0) begin
      hit = 1'b0;
    end
    return {hit, (hit ? data : {DATA_WIDTH{1'b0}})};
  endfunction

  always_comb begin
    {fwd1_hit, fwd1_data} = lookup(ra1);
    {fwd2_hit, fwd2_data} = lookup(ra2);
  end

endmodule

// File: tb/tb_wb_write_queue.sv
// Bench for wb_write_queue: directed scenarios plus random traffic against a queue-based reference model.
module tb_wb_write_queue;

  localparam int DW    = 64;
  localparam int AW    = 5;
  localparam int DEPTH = 4;

  logic          clk;
  logic          reset;
  logic          mem_valid;
  logic [AW-1:0] mem_wa;
  logic [DW-1:0] mem_wd;
  logic          alu_valid;
  logic [AW-1:0] alu_wa;
  logic [DW-1:0] alu_wd;
  logic          in_ready;
  logic          overflow;
  logic [AW-1:0] ra1;
  logic [AW-1:0] ra2;
  logic          fwd1_hit;
  logic [DW-1:0] fwd1_data;
  logic          fwd2_hit;
  logic [DW-1:0] fwd2_data;
  logic          RegWrite;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;

  int vectors;
  int miscompares;

  wb_write_queue #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_wa(mem_wa), .mem_wd(mem_wd),
    .alu_valid(alu_valid), .alu_wa(alu_wa), .alu_wd(alu_wd),
    .in_ready(in_ready), .overflow(overflow),
    .ra1(ra1), .ra2(ra2),
    .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
    .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
    .RegWrite(RegWrite), .wa(wa), .wd(wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending writes as a plain queue, oldest at index 0.
  typedef struct packed {
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
  } ent_t;

  ent_t          mq[$];
  logic          m_we  = 1'b0;
  logic [AW-1:0] m_wa  = '0;
  logic [DW-1:0] m_wd  = '0;
  logic          m_ovf = 1'b0;

  function automatic void model_step();
    bit rdy;
    if (reset) begin
      mq.delete();
      m_we = 1'b0; m_wa = '0; m_wd = '0; m_ovf = 1'b0;
    end else begin
      rdy = (mq.size() <= DEPTH - 2);
      if (mq.size() > 0) begin
        m_we = 1'b1; m_wa = mq[0].wa; m_wd = mq[0].wd;
        void'(mq.pop_front());
      end else begin
        m_we = 1'b0;
      end
      if (mem_valid && mem_wa != 0) begin
        if (rdy) mq.push_back('{wa: mem_wa, wd: mem_wd});
        else m_ovf = 1'b1;
      end
      if (alu_valid && alu_wa != 0) begin
        if (rdy) mq.push_back('{wa: alu_wa, wd: alu_wd});
        else m_ovf = 1'b1;
      end
    end
  endfunction

  function automatic logic [DW:0] model_fwd(input logic [AW-1:0] ra);
    logic          h;
    logic [DW-1:0] d;
    h = 1'b0; d = '0;
    if (ra != 0) begin
      if (m_we && m_wa == ra) begin h = 1'b1; d = m_wd; end
      foreach (mq[i]) if (mq[i].wa == ra) begin h = 1'b1; d = mq[i].wd; end
    end
    return {h, d};
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    mem_valid = 1'b0; mem_wa = '0; mem_wd = '0;
    alu_valid = 1'b0; alu_wa = '0; alu_wd = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ra1 = '0; ra2 = '0;
    mem_valid = 1'b1; mem_wa = 5'd9; mem_wd = 64'h55;
    alu_valid = 1'b1; alu_wa = 5'd10; alu_wd = 64'h66;
    cycle();
    cycle();
    vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL reset_regwrite: got %0b want 0", RegWrite); end
    vectors++; if (wa !== 5'd0) begin miscompares++; $display("FAIL reset_wa: got %0h want 0", wa); end
    vectors++; if (wd !== 64'd0) begin miscompares++; $display("FAIL reset_wd: got %0h want 0", wd); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready_during: got %0b want 0", in_ready); end
    reset = 1'b0; idle();
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready_after: got %0b want 1", in_ready); end
  endtask

  task automatic test_single();
    idle(); alu_valid = 1'b1; alu_wa = 5'd5; alu_wd = 64'hAA; ra1 = 5'd5; ra2 = '0;
    cycle();
    idle(); #1;
    vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL single_not_yet: got %0b want 0", RegWrite); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL single_in_ready: got %0b want 1", in_ready); end
    vectors++; if (fwd1_hit !== 1'b1 || fwd1_data !== 64'hAA) begin miscompares++; $display("FAIL single_fwd_queued: got %0b/%0h want 1/aa", fwd1_hit, fwd1_data); end
    cycle();
    vectors++; if (RegWrite !== 1'b1 || wa !== 5'd5 || wd !== 64'hAA) begin miscompares++; $display("FAIL single_write: got %0b/%0h/%0h want 1/5/aa", RegWrite, wa, wd); end
    cycle();
    vectors++; if (RegWrite !== 1'b0 || wa !== 5'd5) begin miscompares++; $display("FAIL single_one_cycle: got %0b/%0h want 0/5", RegWrite, wa); end
  endtask

  task automatic test_dual();
    idle(); ra1 = '0;
    mem_valid = 1'b1; mem_wa = 5'd3; mem_wd = 64'd1;
    alu_valid = 1'b1; alu_wa = 5'd4; alu_wd = 64'd2;
    cycle();
    idle();
    cycle();
    vectors++; if (RegWrite !== 1'b1 || wa !== 5'd3 || wd !== 64'd1) begin miscompares++; $display("FAIL dual_first_mem: got %0b/%0h/%0h want 1/3/1", RegWrite, wa, wd); end
    cycle();
    vectors++; if (RegWrite !== 1'b1 || wa !== 5'd4 || wd !== 64'd2) begin miscompares++; $display("FAIL dual_second_alu: got %0b/%0h/%0h want 1/4/2", RegWrite, wa, wd); end
    cycle();
    vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL dual_drained: got %0b want 0", RegWrite); end
  endtask

  task automatic test_x0();
    idle(); alu_valid = 1'b1; alu_wa = 5'd0; alu_wd = 64'hFF; ra1 = 5'd0;
    cycle();
    idle(); #1;
    vectors++; if (fwd1_hit !== 1'b0 || fwd1_data !== 64'd0) begin miscompares++; $display("FAIL x0_fwd: got %0b/%0h want 0/0", fwd1_hit, fwd1_data); end
    cycle();
    vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL x0_no_write: got %0b want 0", RegWrite); end
    vectors++; if (overflow !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL x0_state: got ovf %0b rdy %0b want 0/1", overflow, in_ready); end
  endtask

  task automatic test_fwd_chain();
    idle(); ra1 = 5'd7; ra2 = 5'd8;
    alu_valid = 1'b1; alu_wa = 5'd7; alu_wd = 64'd10;
    cycle();
    alu_wd = 64'd20;
    cycle();
    #1;
    vectors++; if (fwd1_hit !== 1'b1 || fwd1_data !== 64'd20) begin miscompares++; $display("FAIL fwd_mid: got %0b/%0d want 1/20", fwd1_hit, fwd1_data); end
    alu_wd = 64'd30;
    cycle();
    idle(); #1;
    vectors++; if (fwd1_hit !== 1'b1 || fwd1_data !== 64'd30) begin miscompares++; $display("FAIL fwd_youngest: got %0b/%0d want 1/30", fwd1_hit, fwd1_data); end
    vectors++; if (fwd2_hit !== 1'b0 || fwd2_data !== 64'd0) begin miscompares++; $display("FAIL fwd_miss_ra2: got %0b/%0h want 0/0", fwd2_hit, fwd2_data); end
    vectors++; if (RegWrite !== 1'b1 || wd !== 64'd20) begin miscompares++; $display("FAIL fwd_drain20: got %0b/%0d want 1/20", RegWrite, wd); end
    cycle();
    vectors++; if (fwd1_hit !== 1'b1 || fwd1_data !== 64'd30 || wd !== 64'd30) begin miscompares++; $display("FAIL fwd_from_port: got %0b/%0d wd %0d want 1/30 wd 30", fwd1_hit, fwd1_data, wd); end
    cycle();
    vectors++; if (fwd1_hit !== 1'b0 || fwd1_data !== 64'd0) begin miscompares++; $display("FAIL fwd_gone: got %0b/%0h want 0/0", fwd1_hit, fwd1_data); end
  endtask

  task automatic test_overflow();
    logic [AW-1:0] got_wa[$];
    logic [DW-1:0] got_wd[$];
    logic [AW-1:0] exp_wa [4];
    exp_wa = '{5'd10, 5'd11, 5'd12, 5'd13};
    idle(); ra1 = '0; ra2 = '0;
    mem_valid = 1'b1; alu_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      mem_wa = AW'(10 + 2 * c); mem_wd = 64'h100 + 64'(2 * c);
      alu_wa = AW'(11 + 2 * c); alu_wd = 64'h101 + 64'(2 * c);
      #1;
      if (c == 2) begin
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL ovf_in_ready_low: got %0b want 0", in_ready); end
      end else begin
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL ovf_in_ready_high c%0d: got %0b want 1", c, in_ready); end
      end
      cycle();
      if (RegWrite) begin got_wa.push_back(wa); got_wd.push_back(wd); end
    end
    idle(); #1;
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %0b want 1", overflow); end
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (RegWrite) begin got_wa.push_back(wa); got_wd.push_back(wd); end
    end
    vectors++; if (got_wa.size() != 4) begin miscompares++; $display("FAIL ovf_accepted_count: got %0d want 4", got_wa.size()); end
    for (int i = 0; i < 4 && i < got_wa.size(); i++) begin
      vectors++;
      if (got_wa[i] !== exp_wa[i] || got_wd[i] !== 64'h100 + 64'(i)) begin
        miscompares++; $display("FAIL ovf_order[%0d]: got %0h/%0h want %0h/%0h", i, got_wa[i], got_wd[i], exp_wa[i], 64'h100 + 64'(i));
      end
    end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_still_set: got %0b want 1", overflow); end
  endtask

  task automatic test_reset_mid();
    idle();
    mem_valid = 1'b1; mem_wa = 5'd20; mem_wd = 64'd1;
    alu_valid = 1'b1; alu_wa = 5'd21; alu_wd = 64'd2;
    cycle();
    mem_wa = 5'd22; alu_wa = 5'd23;
    cycle();
    idle(); reset = 1'b1;
    cycle();
    vectors++; if (RegWrite !== 1'b0 || overflow !== 1'b0 || in_ready !== 1'b0) begin miscompares++; $display("FAIL rstmid_state: got we %0b ovf %0b rdy %0b want 0/0/0", RegWrite, overflow, in_ready); end
    reset = 1'b0; #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_in_ready: got %0b want 1", in_ready); end
    for (int c = 0; c < 3; c++) begin
      cycle();
      vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL rstmid_lost c%0d: got %0b want 0", c, RegWrite); end
    end
  endtask

  task automatic test_random();
    logic [DW:0] f1;
    logic [DW:0] f2;
    logic        e_rdy;
    for (int n = 0; n < 500; n++) begin
      reset     = ($urandom_range(0, 39) == 0);
      mem_valid = $urandom_range(0, 1);
      mem_wa    = AW'($urandom_range(0, 7));
      mem_wd    = {$urandom, $urandom};
      alu_valid = $urandom_range(0, 1);
      alu_wa    = AW'($urandom_range(0, 7));
      alu_wd    = {$urandom, $urandom};
      ra1       = AW'($urandom_range(0, 7));
      ra2       = AW'($urandom_range(0, 7));
      #1;
      e_rdy = !reset && (mq.size() <= DEPTH - 2);
      f1 = model_fwd(ra1);
      f2 = model_fwd(ra2);
      vectors++; if (in_ready !== e_rdy) begin miscompares++; $display("FAIL rnd_in_ready n%0d: got %0b want %0b", n, in_ready, e_rdy); end
      vectors++; if ({fwd1_hit, fwd1_data} !== f1) begin miscompares++; $display("FAIL rnd_fwd1 n%0d ra %0d: got %0b/%0h want %0b/%0h", n, ra1, fwd1_hit, fwd1_data, f1[DW], f1[DW-1:0]); end
      vectors++; if ({fwd2_hit, fwd2_data} !== f2) begin miscompares++; $display("FAIL rnd_fwd2 n%0d ra %0d: got %0b/%0h want %0b/%0h", n, ra2, fwd2_hit, fwd2_data, f2[DW], f2[DW-1:0]); end
      vectors++; if (RegWrite !== m_we || wa !== m_wa || wd !== m_wd) begin miscompares++; $display("FAIL rnd_port n%0d: got %0b/%0h/%0h want %0b/%0h/%0h", n, RegWrite, wa, wd, m_we, m_wa, m_wd); end
      vectors++; if (overflow !== m_ovf) begin miscompares++; $display("FAIL rnd_overflow n%0d: got %0b want %0b", n, overflow, m_ovf); end
      cycle();
    end
    reset = 1'b0; idle();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    idle();
    reset = 1'b1; ra1 = '0; ra2 = '0;
    test_reset();
    test_single();
    test_dual();
    test_x0();
    test_fwd_chain();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
